// File: rtl/bala_pkg.sv
// -----------------------------------------------------------------------------
// bala_pkg
// Shared definitions for the candy-machine vend controller:
//   - bala_state_e : controller state encoding
//   - COIN_*       : coin acceptor codes
//   - coin_value() : coin code -> value in centavos
//   - DEFAULT_PRICE / DEFAULT_CREDIT_MAX : default pricing parameters
// -----------------------------------------------------------------------------
package bala_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ACCUM    = 3'd1,
        ST_DISPENSE = 3'd2,
        ST_CHANGE   = 3'd3,
        ST_REFUND   = 3'd4
    } bala_state_e;

    localparam logic [1:0] COIN_5  = 2'b00;
    localparam logic [1:0] COIN_10 = 2'b01;
    localparam logic [1:0] COIN_25 = 2'b10;
    localparam logic [1:0] COIN_50 = 2'b11;

    // Wide enough for the largest coin (50 centavos).
    localparam int COIN_VAL_W = 6;

    localparam int DEFAULT_PRICE      = 25;
    localparam int DEFAULT_CREDIT_MAX = 200;

    function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [1:0] code);
        logic [COIN_VAL_W-1:0] val;
        unique case (code)
            COIN_5:  val = 6'd5;
            COIN_10: val = 6'd10;
            COIN_25: val = 6'd25;
            default: val = 6'd50;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/bala_vend_ctrl_if.sv
// -----------------------------------------------------------------------------
// bala_vend_ctrl_if
// Bundles the coin acceptor, dispenser handshake and change/status signals of
// the vend controller.
//   master : coin acceptor / dispenser / host side (drives coin, cancel, ack)
//   slave  : the vend controller (drives request, reject, change, status)
// Signals:
//   coin_valid, coin_code[1:0], cancel, disp_ack      (master -> slave)
//   disp_req, coin_reject, change_valid, change_amt,
//   credit, busy, fault                               (slave -> master)
// -----------------------------------------------------------------------------
interface bala_vend_ctrl_if #(
    parameter int CREDIT_W = 8
);
    logic                coin_valid;
    logic [1:0]          coin_code;
    logic                cancel;
    logic                disp_ack;

    logic                disp_req;
    logic                coin_reject;
    logic                change_valid;
    logic [CREDIT_W-1:0] change_amt;
    logic [CREDIT_W-1:0] credit;
    logic                busy;
    logic                fault;

    modport master (
        output coin_valid, coin_code, cancel, disp_ack,
        input  disp_req, coin_reject, change_valid, change_amt, credit, busy, fault
    );

    modport slave (
        input  coin_valid, coin_code, cancel, disp_ack,
        output disp_req, coin_reject, change_valid, change_amt, credit, busy, fault
    );

endinterface

// File: rtl/bala_ack_timer.sv
// -----------------------------------------------------------------------------
// bala_ack_timer
// Loadable, saturating cycle counter that bounds how long the dispense request
// may wait for an acknowledge.
// Ports:
//   clk     : rising-edge clock
//   reset   : synchronous active-low reset
//   start   : clear the count (asserted on the cycle entering DISPENSE)
//   run     : count one cycle (asserted while in DISPENSE)
//   expired : the current cycle is the TIMEOUT-th cycle spent running
// -----------------------------------------------------------------------------
module bala_ack_timer #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    // Count reads 0 in the first DISPENSE cycle, so the last one is TIMEOUT-1.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (run && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/bala_vend_ctrl.sv
// -----------------------------------------------------------------------------
// bala_vend_ctrl
// Candy-machine sequencing controller: accumulates coin credit, holds a
// request/acknowledge handshake to the dispenser once credit reaches PRICE,
// then returns change, or the full credit on cancel or dispenser timeout.
// All outputs are registered.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   bus   : bala_vend_ctrl_if.slave (coin/cancel/ack in; request, reject,
//           change, credit, busy and fault out)
// -----------------------------------------------------------------------------
module bala_vend_ctrl
    import bala_pkg::*;
#(
    parameter int PRICE       = DEFAULT_PRICE,
    parameter int CREDIT_MAX  = DEFAULT_CREDIT_MAX,
    parameter int CREDIT_W    = 8,
    parameter int ACK_TIMEOUT = 1000
) (
    input  logic            clk,
    input  logic            reset,
    bala_vend_ctrl_if.slave bus
);

    // Sums are carried one bit wider so an overflowing sum still compares
    // correctly against CREDIT_MAX.
    localparam logic [CREDIT_W:0]   MAX_SUM   = (CREDIT_W + 1)'(CREDIT_MAX);
    localparam logic [CREDIT_W:0]   PRICE_SUM = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C   = CREDIT_W'(PRICE);

    bala_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
    logic                coin_reject_q, coin_reject_d;
    logic                change_valid_q, change_valid_d;
    logic                fault_q, fault_d;
    logic                disp_req_q, busy_q;

    logic [CREDIT_W:0]   sum;
    logic [CREDIT_W-1:0] remain;
    logic                timer_start, timer_run, timer_expired;

    assign sum    = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(bus.coin_code));
    // Cannot underflow: DISPENSE is only entered with credit >= PRICE.
    assign remain = credit_q - PRICE_C;

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        coin_reject_d  = 1'b0;
        change_valid_d = 1'b0;
        change_amt_d   = '0;
        fault_d        = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (bus.cancel) begin
                    // Cancel has priority; a coin in the same cycle bounces.
                    coin_reject_d = bus.coin_valid;
                    if (credit_q != '0) begin
                        state_d        = ST_REFUND;
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                    end
                end else if (bus.coin_valid) begin
                    if (sum <= MAX_SUM) begin
                        credit_d = sum[CREDIT_W-1:0];
                        state_d  = (sum >= PRICE_SUM) ? ST_DISPENSE : ST_ACCUM;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
            end

            ST_DISPENSE: begin
                // The dispense is committed: cancel is ignored, coins bounce.
                coin_reject_d = bus.coin_valid;
                if (bus.disp_ack) begin
                    credit_d = remain;
                    if (remain != '0) begin
                        state_d        = ST_CHANGE;
                        change_valid_d = 1'b1;
                        change_amt_d   = remain;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (timer_expired) begin
                    // Dispenser never answered: refund without deducting.
                    state_d        = ST_REFUND;
                    fault_d        = 1'b1;
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                end
            end

            ST_CHANGE, ST_REFUND: begin
                coin_reject_d = bus.coin_valid;
                credit_d      = '0;
                state_d       = ST_IDLE;
            end

            default: begin
                state_d  = ST_IDLE;
                credit_d = '0;
            end
        endcase
    end

    assign timer_start = (state_d == ST_DISPENSE) && (state_q != ST_DISPENSE);
    assign timer_run   = (state_q == ST_DISPENSE);

    bala_ack_timer #(
        .TIMEOUT (ACK_TIMEOUT)
    ) u_ack_timer (
        .clk     (clk),
        .reset   (reset),
        .start   (timer_start),
        .run     (timer_run),
        .expired (timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            change_valid_q <= 1'b0;
            fault_q        <= 1'b0;
            disp_req_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_amt_q   <= change_amt_d;
            coin_reject_q  <= coin_reject_d;
            change_valid_q <= change_valid_d;
            fault_q        <= fault_d;
            // Status flags track the state being entered so they line up
            // with the registered state.
            disp_req_q     <= (state_d == ST_DISPENSE);
            busy_q         <= (state_d == ST_DISPENSE) || (state_d == ST_CHANGE) ||
                              (state_d == ST_REFUND);
        end
    end

    assign bus.credit       = credit_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.change_valid = change_valid_q;
    assign bus.fault        = fault_q;
    assign bus.disp_req     = disp_req_q;
    assign bus.busy         = busy_q;

endmodule

// File: doc/bala_vend_ctrl.md
# bala_vend_ctrl

Sequencing controller for the candy-machine (`maquina_bala`) dispenser. It accumulates credit from a coin acceptor and issues a held request/acknowledge handshake to the dispenser mechanism once credit reaches `PRICE`. It then returns change, or the full credit on cancel or dispenser fault. It sits between the coin acceptor front end and the dispenser FSM, and is the only block that drives the dispenser request.

## Interface
- `PRICE`, default 25: candy price in centavos; must satisfy 0 < `PRICE` ≤ `CREDIT_MAX`.
- `CREDIT_MAX`, default 200: credit ceiling in centavos; must be ≤ 2^`CREDIT_W`−1.
- `CREDIT_W`, default 8: width of the credit and change buses.
- `ACK_TIMEOUT`, default 1000: maximum number of cycles `disp_req` may stay high without `disp_ack`.

- `clk`, in, 1: single clock; all logic is rising-edge.
- `reset`, in, 1: synchronous, active-low reset.
- `coin_valid`, in, 1: one-cycle pulse indicating a coin is presented.
- `coin_code`, in, 2: coin value, sampled with `coin_valid`. 00=5, 01=10, 10=25, 11=50 centavos.
- `cancel`, in, 1: one-cycle pulse requesting a refund.
- `disp_ack`, in, 1: one-cycle pulse from the dispenser meaning the candy was released.
- `disp_req`, out, 1: dispense request, held high until acknowledged.
- `coin_reject`, out, 1: one-cycle pulse; the presented coin was not credited.
- `change_valid`, out, 1: one-cycle pulse; `change_amt` is valid.
- `change_amt`, out, `CREDIT_W`: amount to return, in centavos.
- `credit`, out, `CREDIT_W`: current credit.
- `busy`, out, 1: high in every state except IDLE and ACCUM.
- `fault`, out, 1: one-cycle pulse when the dispenser times out.

## Operation
- States:
  - IDLE: credit is 0.
  - ACCUM: 0 < credit < `PRICE`.
  - DISPENSE: `disp_req` is high.
  - CHANGE: one cycle; outputs the remainder.
  - REFUND: one cycle; outputs the full credit.
- IDLE/ACCUM, coin handling:
  - On `coin_valid`, if credit + value ≤ `CREDIT_MAX`, credit += value. Otherwise the coin is rejected and credit is unchanged.
  - Next state: DISPENSE if the new credit ≥ `PRICE`, else ACCUM. A coin rejected in IDLE leaves the block in IDLE.
- IDLE/ACCUM, cancel:
  - `cancel` with credit > 0 goes to REFUND.
  - `cancel` in IDLE with credit 0 is ignored.
  - `cancel` and `coin_valid` in the same cycle: cancel wins and the coin is rejected.
- DISPENSE:
  - `disp_ack` sets credit to credit − `PRICE`. Next state is CHANGE if the result > 0, else IDLE.
  - If `ACK_TIMEOUT` cycles elapse without `disp_ack`: pulse `fault`, go to REFUND, and leave credit undeducted.
  - Coins arriving here are rejected. `cancel` is ignored, because the dispense is committed.
- CHANGE and REFUND:
  - `change_valid` = 1 and `change_amt` = credit, for exactly one cycle.
  - Credit is then cleared to 0 and the next state is IDLE.
  - Coins arriving in these states are rejected.
- `disp_ack` outside DISPENSE is ignored.
- Arithmetic:
  - The credit sum is computed at `CREDIT_W`+1 bits so overflow is detected before the `CREDIT_MAX` comparison.
  - The `PRICE` subtraction cannot underflow, since DISPENSE is entered only when credit ≥ `PRICE`.
- Timeout counter: cleared on DISPENSE entry, increments each DISPENSE cycle, and saturates.

## Timing
- Reset values: state IDLE; credit 0, change_amt 0; `disp_req`, `coin_reject`, `change_valid`, `busy`, `fault` all 0. Reset asserted mid-DISPENSE drops `disp_req` on the next edge and loses credit; this is accepted by design.
- All outputs are registered.
- Coin latency: `coin_valid` at edge N gives the updated `credit`, or the `coin_reject` pulse, at N+1. If the threshold is reached, `disp_req` = 1 from N+1.
- `disp_ack` at edge M gives `disp_req` = 0 and credit reduced at M+1. `change_valid` is at M+1 if a remainder exists, and IDLE is reached at M+2.
- Timeout: `disp_req` rises at D. If no `disp_ack` arrives, `fault` pulses at D+`ACK_TIMEOUT`, with REFUND in that same cycle.
- `cancel` at N gives REFUND with `change_valid` at N+1, then credit 0 and IDLE at N+2.
- Accepts at most one coin per cycle, with no back-pressure to the acceptor.

## Structure
- Package `bala_pkg` holds:
  - the state enum;
  - the coin code constants;
  - the function `coin_value(code)`, returning centavos;
  - the default `PRICE` and `CREDIT_MAX`.
- Sub-module `bala_ack_timer` is the loadable, saturating timeout counter with inputs `start`, `run` and output `expired`. Everything else stays in one FSM with registered outputs.

## Test plan
All scenarios use `PRICE`=25, `CREDIT_MAX`=200 and `ACK_TIMEOUT`=16.
- Exact payment: one 25 coin → `credit` 25 and `disp_req`=1 one cycle later. `disp_ack` → `disp_req`=0, credit 0, IDLE, and no `change_valid`.
- Overpayment: 10, 10, 50 → credit sequence 10, 20, 70; `disp_req` after the 50. `disp_ack` → `change_valid` with `change_amt`=45, then credit 0.
- Cancel: 5, 10, then `cancel` → `change_valid` with `change_amt`=15, then IDLE. Coin and cancel in the same cycle → `coin_reject` plus refund of the prior credit only.
- Saturation: in a test configuration with `PRICE`=200, pay 50 four times to reach credit 200, then a further coin of 5 → `coin_reject` and credit unchanged. A coin presented during DISPENSE → `coin_reject`.
- Timeout: pay 25 and withhold `disp_ack` → `fault` 16 cycles after `disp_req` rises, then `change_valid` with `change_amt`=25 and IDLE.
- Reset mid-DISPENSE: drive `reset`=0 for one edge → all outputs at their reset values on the next cycle.
